// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter with fixed-priority or round-robin selection,
// locked multi-cycle transfers and an ack timeout that releases a stalled grant.
module bus_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int MODE        = 0,
   parameter int TIMEOUT     = 255
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [NUM_MASTERS-1:0]        i_m_cs,
   input  logic [NUM_MASTERS-1:0]        i_m_we,
   input  logic [NUM_MASTERS-1:0]        i_m_lock,
   input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat,
   output logic [NUM_MASTERS-1:0]        o_m_ack,
   output logic [NUM_MASTERS-1:0]        o_m_err,
   output logic [NUM_MASTERS-1:0]        o_grant,
   output logic [ADDR_W-1:0]             o_addr,
   output logic [DATA_W-1:0]             o_dat,
   output logic                          o_we,
   output logic                          o_cs,
   input  logic                          i_ack
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
   // Expiry is flagged in the cycle the counter would step onto TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(NUM_MASTERS);

   typedef enum logic {S_IDLE, S_GRANTED} state_t;

   state_t                 r_state;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [IDX_W-1:0]       r_ptr;
   logic [CNT_W-1:0]       r_tcnt;

   logic [NUM_MASTERS-1:0] w_req;
   logic [NUM_MASTERS-1:0] w_win_oh;
   logic [IDX_W-1:0]       w_start;
   logic [IDX_W-1:0]       w_win;
   logic [IDX_W-1:0]       w_idx;
   logic [IDX_W:0]         w_sum;
   logic                   w_found;
   logic                   w_cs_g;
   logic                   w_lock_g;
   logic                   w_ack;
   logic                   w_expire;
   logic                   w_release;

   assign w_cs_g    = |(i_m_cs & r_grant);
   assign w_lock_g  = |(i_m_lock & r_grant);
   assign w_ack     = i_ack & w_cs_g;
   assign w_expire  = (TIMEOUT > 0) && w_cs_g && !i_ack && (r_tcnt == CNT_LAST);
   assign w_release = (w_ack & ~w_lock_g) | ~w_cs_g | w_expire;

   // The current holder is masked so a releasing master cannot immediately re-win.
   always_comb begin
      w_req   = (r_state == S_IDLE) ? i_m_cs : (i_m_cs & ~r_grant);
      w_start = '0;
      if (MODE != 0) begin
         w_start = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
      end
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_sum = {1'b0, w_start} + (IDX_W + 1)'(i);
         if (w_sum >= N_EXT) begin
            w_sum = w_sum - N_EXT;
         end
         w_idx = w_sum[IDX_W-1:0];
         if (!w_found && w_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
      w_win_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_ptr   <= LAST_IDX;
         r_tcnt  <= '0;
      end else if (r_state == S_IDLE || w_release) begin
         r_tcnt <= '0;
         if (w_found) begin
            r_state <= S_GRANTED;
            r_grant <= w_win_oh;
            r_ptr   <= w_win;
         end else begin
            r_state <= S_IDLE;
            r_grant <= '0;
         end
      end else if (w_ack) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   assign o_grant = r_grant;

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign o_m_ack[gi] = i_ack & i_m_cs[gi] & r_grant[gi];
      assign o_m_err[gi] = w_expire & r_grant[gi];
   end

   // r_grant is one-hot or zero, so an AND-OR mux yields zeros while idle.
   always_comb begin
      o_addr = '0;
      o_dat  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (r_grant[k]) begin
            o_addr = o_addr | i_m_addr[k*ADDR_W +: ADDR_W];
            o_dat  = o_dat | i_m_dat[k*DATA_W +: DATA_W];
         end
      end
      o_we = |(i_m_we & r_grant);
      o_cs = w_cs_g;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter: a fixed-priority and a round-robin instance
// share stimulus; each row names which instance it checks.
module tb_bus_arbiter;

   localparam logic [2:0] WE_PAT = 3'b010;

   typedef struct {
      logic       rst;
      logic       sel;     // 0 = fixed-priority instance, 1 = round-robin instance
      logic [2:0] cs;
      logic [2:0] lock;
      logic       ack;
      logic [2:0] grant;
      logic [2:0] mack;
      logic [2:0] merr;
   } vec_t;

   typedef struct {
      logic        sel;
      logic [2:0]  grant;
      logic [2:0]  mack;
      logic [2:0]  merr;
      logic        ocs;
      logic        owe;
      logic [15:0] addr;
      logic [7:0]  dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cs, we, lock;
   logic        ack;
   logic [47:0] m_addr;
   logic [23:0] m_dat;
   logic [15:0] addr_of [3];
   logic [7:0]  dat_of  [3];

   logic [2:0]  f_mack, f_merr, f_grant, r_mack, r_merr, r_grant;
   logic [15:0] f_addr, r_addr;
   logic [7:0]  f_dat, r_dat;
   logic        f_we, f_cs, r_we, r_cs;

   int n_tests = 0;
   int n_fail  = 0;
   int n_row   = 0;
   exp_t sb_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .MODE(0), .TIMEOUT(4)) dut_fix (
      .i_clk(clk), .i_reset(rst), .i_m_cs(cs), .i_m_we(we), .i_m_lock(lock),
      .i_m_addr(m_addr), .i_m_dat(m_dat), .o_m_ack(f_mack), .o_m_err(f_merr),
      .o_grant(f_grant), .o_addr(f_addr), .o_dat(f_dat), .o_we(f_we), .o_cs(f_cs),
      .i_ack(ack)
   );

   bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .MODE(1), .TIMEOUT(4)) dut_rr (
      .i_clk(clk), .i_reset(rst), .i_m_cs(cs), .i_m_we(we), .i_m_lock(lock),
      .i_m_addr(m_addr), .i_m_dat(m_dat), .o_m_ack(r_mack), .o_m_err(r_merr),
      .o_grant(r_grant), .o_addr(r_addr), .o_dat(r_dat), .o_we(r_we), .o_cs(r_cs),
      .i_ack(ack)
   );

   function automatic vec_t mk(input logic r, input logic s, input logic [2:0] c,
                               input logic [2:0] l, input logic a, input logic [2:0] g,
                               input logic [2:0] ma, input logic [2:0] me);
      vec_t v;
      v.rst = r; v.sel = s; v.cs = c; v.lock = l; v.ack = a;
      v.grant = g; v.mack = ma; v.merr = me;
      return v;
   endfunction

   // Slave-side expectations follow from the expected grant and the driven requests.
   function automatic exp_t mk_exp(input vec_t v);
      exp_t e;
      e.sel = v.sel; e.grant = v.grant; e.mack = v.mack; e.merr = v.merr;
      e.ocs = |(v.grant & v.cs);
      e.owe = |(v.grant & WE_PAT);
      e.addr = '0;
      e.dat  = '0;
      for (int k = 0; k < 3; k++) begin
         if (v.grant[k]) begin
            e.addr = addr_of[k];
            e.dat  = dat_of[k];
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL row %0d %s: got %h expected %h", n_row, name, act, req);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      rst = v.rst; cs = v.cs; lock = v.lock; ack = v.ack;
      sb_q.push_back(mk_exp(v));
      @(negedge clk);
      e = sb_q.pop_front();
      if (e.sel == 1'b0) begin
         chk("grant", 32'(f_grant), 32'(e.grant));
         chk("m_ack", 32'(f_mack),  32'(e.mack));
         chk("m_err", 32'(f_merr),  32'(e.merr));
         chk("o_cs",  32'(f_cs),    32'(e.ocs));
         chk("o_we",  32'(f_we),    32'(e.owe));
         chk("o_addr", 32'(f_addr), 32'(e.addr));
         chk("o_dat", 32'(f_dat),   32'(e.dat));
      end else begin
         chk("grant", 32'(r_grant), 32'(e.grant));
         chk("m_ack", 32'(r_mack),  32'(e.mack));
         chk("m_err", 32'(r_merr),  32'(e.merr));
         chk("o_cs",  32'(r_cs),    32'(e.ocs));
         chk("o_we",  32'(r_we),    32'(e.owe));
         chk("o_addr", 32'(r_addr), 32'(e.addr));
         chk("o_dat", 32'(r_dat),   32'(e.dat));
      end
      $display("[TB] row %0d sel=%0d rst=%b cs=%b lock=%b ack=%b exp_grant=%b exp_ack=%b exp_err=%b",
               n_row, v.sel, v.rst, v.cs, v.lock, v.ack, v.grant, v.mack, v.merr);
      n_row++;
   endtask

   initial begin
      addr_of[0] = 16'h1234; addr_of[1] = 16'h5678; addr_of[2] = 16'h9ABC;
      dat_of[0]  = 8'h11;    dat_of[1]  = 8'h22;    dat_of[2]  = 8'h33;
      m_addr = {addr_of[2], addr_of[1], addr_of[0]};
      m_dat  = {dat_of[2], dat_of[1], dat_of[0]};
      we = WE_PAT;
      rst = 1'b1; cs = '0; lock = '0; ack = 1'b0;

      // Reset state on both instances
      tbl.push_back(mk(0,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      tbl.push_back(mk(0,1,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      // Fixed priority: 0 and 2 together, ack two cycles after o_cs, no idle bubble
      tbl.push_back(mk(0,0,3'b101,3'b000,0, 3'b000,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b101,3'b000,0, 3'b001,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b101,3'b000,0, 3'b001,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b101,3'b000,1, 3'b001,3'b001,3'b000));
      tbl.push_back(mk(0,0,3'b100,3'b000,0, 3'b100,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b100,3'b000,0, 3'b100,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b100,3'b000,1, 3'b100,3'b100,3'b000));
      tbl.push_back(mk(0,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      tbl.push_back(mk(1,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      // Round-robin: all request, ack every cycle; ack ignored while idle
      tbl.push_back(mk(0,1,3'b111,3'b000,1, 3'b000,3'b000,3'b000));
      tbl.push_back(mk(0,1,3'b111,3'b000,1, 3'b001,3'b001,3'b000));
      tbl.push_back(mk(0,1,3'b111,3'b000,1, 3'b010,3'b010,3'b000));
      tbl.push_back(mk(0,1,3'b111,3'b000,1, 3'b100,3'b100,3'b000));
      tbl.push_back(mk(0,1,3'b111,3'b000,1, 3'b001,3'b001,3'b000));
      tbl.push_back(mk(0,1,3'b000,3'b000,0, 3'b010,3'b000,3'b000));
      tbl.push_back(mk(0,1,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      tbl.push_back(mk(1,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      // Lock: master 1 keeps grant across two acks while master 0 waits
      tbl.push_back(mk(0,0,3'b010,3'b010,0, 3'b000,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b011,3'b010,0, 3'b010,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b011,3'b010,1, 3'b010,3'b010,3'b000));
      tbl.push_back(mk(0,0,3'b011,3'b010,1, 3'b010,3'b010,3'b000));
      tbl.push_back(mk(0,0,3'b011,3'b000,0, 3'b010,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b011,3'b000,1, 3'b010,3'b010,3'b000));
      tbl.push_back(mk(0,0,3'b001,3'b000,0, 3'b001,3'b000,3'b000));
      tbl.push_back(mk(0,0,3'b001,3'b000,1, 3'b001,3'b001,3'b000));
      tbl.push_back(mk(0,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);

      // Timeout: err on the 4th waiting cycle, grant passes to master 1, which then withdraws
      apply(mk(1,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(0,0,3'b001,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(0,0,3'b011,3'b000,0, 3'b001,3'b000,3'b000));
      apply(mk(0,0,3'b011,3'b000,0, 3'b001,3'b000,3'b000));
      apply(mk(0,0,3'b011,3'b000,0, 3'b001,3'b000,3'b000));
      apply(mk(0,0,3'b011,3'b000,0, 3'b001,3'b000,3'b001));
      apply(mk(0,0,3'b010,3'b000,0, 3'b010,3'b000,3'b000));
      apply(mk(0,0,3'b000,3'b000,1, 3'b010,3'b000,3'b000));
      apply(mk(0,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));

      // Ack arriving in the expiry cycle wins over the timeout
      apply(mk(1,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(0,0,3'b001,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(0,0,3'b001,3'b000,0, 3'b001,3'b000,3'b000));
      apply(mk(0,0,3'b001,3'b000,0, 3'b001,3'b000,3'b000));
      apply(mk(0,0,3'b001,3'b000,0, 3'b001,3'b000,3'b000));
      apply(mk(0,0,3'b001,3'b000,1, 3'b001,3'b001,3'b000));
      apply(mk(0,0,3'b000,3'b000,0, 3'b000,3'b000,3'b000));

      // Reset while granted; round-robin must restart at master 0
      apply(mk(1,1,3'b000,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(0,1,3'b010,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(1,1,3'b010,3'b000,0, 3'b010,3'b000,3'b000));
      apply(mk(0,1,3'b111,3'b000,0, 3'b000,3'b000,3'b000));
      apply(mk(0,1,3'b111,3'b000,1, 3'b001,3'b001,3'b000));
      apply(mk(0,1,3'b000,3'b000,0, 3'b010,3'b000,3'b000));
      apply(mk(0,1,3'b000,3'b000,0, 3'b000,3'b000,3'b000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
